// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: the one-cycle response encoding used by the device-side
// blocks, plus the mapping from an accepted beat to its response.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_RSP_NONE = 2'd0,
    WB_RSP_ACK  = 2'd1,
    WB_RSP_ERR  = 2'd2
  } wb_rsp_e;

  // Writes are completed with ack; this device class has nothing to return on reads.
  function automatic wb_rsp_e wb_rsp_for(input logic accept, input logic we);
    if (!accept) begin
      return WB_RSP_NONE;
    end else if (we) begin
      return WB_RSP_ACK;
    end else begin
      return WB_RSP_ERR;
    end
  endfunction

endpackage

// File: rtl/wishbone.sv
// Pipelined Wishbone bundle; names are seen from the device side (_i driven by the
// controller, _o driven by the device).
interface wishbone #(parameter int DAT_WIDTH = 8);

  logic                 clk_i;
  logic                 rst_i;
  logic                 cyc_i;
  logic                 stb_i;
  logic                 we_i;
  logic [DAT_WIDTH-1:0] dat_i;
  logic                 ack_o;
  logic                 err_o;
  logic                 rty_o;
  logic                 stall_o;

  modport device (
    input  clk_i, rst_i, cyc_i, stb_i, we_i, dat_i,
    output ack_o, err_o, rty_o, stall_o
  );

  modport controller (
    input  clk_i, rst_i, ack_o, err_o, rty_o, stall_o,
    output cyc_i, stb_i, we_i, dat_i
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with a separate occupancy counter.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push_s, do_pop_s;

  assign full_o    = (level_q == FULL_LVL);
  assign empty_o   = (level_q == (AW+1)'(0));
  assign do_push_s = push_i & ~full_o;
  assign do_pop_s  = pop_i & ~empty_o;
  assign level_o   = level_q;
  assign dout_o    = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; pointers wrap naturally at the power-of-two depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: an entry is only observable after it has been written.
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/wb_stream_sink.sv
// Wishbone write sink: accepted write beats are queued and replayed on a valid/ready
// stream; reads are rejected with err, and the bus is stalled only while the queue is full.
module wb_stream_sink
  import wb_pkg::*;
#(
  parameter int DAT_WIDTH = 8,
  parameter int DEPTH     = 16
) (
  wishbone.device                 wb,
  output logic [DAT_WIDTH-1:0]    m_data_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic [$clog2(DEPTH):0]  level_o
);

  logic    clk_s, rst_n_s;
  logic    full_s, empty_s;
  logic    accept_s, push_s, pop_s;
  wb_rsp_e rsp_d, rsp_q;

  assign clk_s   = wb.clk_i;
  assign rst_n_s = wb.rst_i;

  // stall depends only on stored occupancy, so a same-cycle pop cannot unblock a beat.
  assign accept_s = wb.cyc_i & wb.stb_i & ~full_s;
  assign push_s   = accept_s & wb.we_i;
  assign pop_s    = ~empty_s & m_ready_i;

  always_comb begin
    rsp_d = wb_rsp_for(accept_s, wb.we_i);
  end

  always_ff @(posedge clk_s or negedge rst_n_s) begin
    if (!rst_n_s) begin
      rsp_q <= WB_RSP_NONE;
    end else begin
      rsp_q <= rsp_d;
    end
  end

  assign wb.ack_o   = (rsp_q == WB_RSP_ACK);
  assign wb.err_o   = (rsp_q == WB_RSP_ERR);
  assign wb.rty_o   = 1'b0;
  assign wb.stall_o = full_s;
  assign m_valid_o  = ~empty_s;

  sync_fifo #(
    .WIDTH (DAT_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_s),
    .rst_ni  (rst_n_s),
    .push_i  (push_s),
    .din_i   (wb.dat_i),
    .pop_i   (pop_s),
    .dout_o  (m_data_o),
    .full_o  (full_s),
    .empty_o (empty_s),
    .level_o (level_o)
  );

endmodule

// File: tb/tb_wb_stream_sink.sv
// Directed bench for wb_stream_sink: a queue models the FIFO contents and bus response,
// and every clock the DUT outputs are compared against it.
module tb_wb_stream_sink;

  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic [4:0]    level;

  wishbone #(.DAT_WIDTH(DW)) wb_if ();

  wb_stream_sink #(.DAT_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .wb        (wb_if),
    .m_data_o  (m_data),
    .m_valid_o (m_valid),
    .m_ready_i (m_ready),
    .level_o   (level)
  );

  assign wb_if.clk_i = clk;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic cyc, input logic stb, input logic we, input logic [DW-1:0] dat);
    wb_if.cyc_i = cyc;
    wb_if.stb_i = stb;
    wb_if.we_i  = we;
    wb_if.dat_i = dat;
  endtask

  // One clock: predict accept/pop from the model, advance, then compare all outputs.
  task automatic cycle();
    logic acc, we;
    acc = wb_if.cyc_i & wb_if.stb_i & (sb.size() < DEPTH);
    we  = wb_if.we_i;
    if (m_ready && sb.size() > 0) begin
      chk("pop_data", {24'd0, m_data}, {24'd0, sb.pop_front()});
    end
    if (acc && we) sb.push_back(wb_if.dat_i);
    @(posedge clk);
    #1;
    chk("ack",   {31'd0, wb_if.ack_o},   {31'd0, acc & we});
    chk("err",   {31'd0, wb_if.err_o},   {31'd0, acc & ~we});
    chk("rty",   {31'd0, wb_if.rty_o},   32'd0);
    chk("level", {27'd0, level},         sb.size());
    chk("stall", {31'd0, wb_if.stall_o}, {31'd0, sb.size() == DEPTH});
    chk("valid", {31'd0, m_valid},       {31'd0, sb.size() != 0});
    if (sb.size() != 0) chk("head", {24'd0, m_data}, {24'd0, sb[0]});
  endtask

  initial begin
    wb_if.rst_i = 1'b0;
    m_ready     = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack",   {31'd0, wb_if.ack_o},   32'd0);
    chk("rst_stall", {31'd0, wb_if.stall_o}, 32'd0);
    chk("rst_valid", {31'd0, m_valid},       32'd0);
    chk("rst_level", {27'd0, level},         32'd0);
    wb_if.rst_i = 1'b1;

    // Three back-to-back writes, no consumer.
    drive(1'b1, 1'b1, 1'b1, 8'h11); cycle();
    drive(1'b1, 1'b1, 1'b1, 8'h22); cycle();
    drive(1'b1, 1'b1, 1'b1, 8'h33); cycle();
    drive(1'b0, 1'b0, 1'b0, 8'h00); cycle();
    chk("t2_level", {27'd0, level},  32'd3);
    chk("t2_head",  {24'd0, m_data}, 32'h11);

    // Reset mid-stream with an err response pending.
    drive(1'b1, 1'b1, 1'b0, 8'h00); cycle();
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    wb_if.rst_i = 1'b0;
    #1;
    chk("t1_err",   {31'd0, wb_if.err_o}, 32'd0);
    chk("t1_ack",   {31'd0, wb_if.ack_o}, 32'd0);
    chk("t1_valid", {31'd0, m_valid},     32'd0);
    chk("t1_data",  {24'd0, m_data},      32'd0);
    chk("t1_level", {27'd0, level},       32'd0);
    sb.delete();
    cycle();
    wb_if.rst_i = 1'b1;
    cycle();

    // Fill to full; the 17th strobe is held until a pop has freed a slot.
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 1'b1, 1'b1, 8'h40 + 8'(i));
      cycle();
    end
    chk("t3_stall", {31'd0, wb_if.stall_o}, 32'd1);
    m_ready = 1'b1;
    cycle();
    chk("t3_still_stalled", {31'd0, wb_if.ack_o}, 32'd0);
    cycle();
    chk("t3_accepted", {31'd0, wb_if.ack_o}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    repeat (18) cycle();

    // Read beat against a non-empty queue.
    m_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 8'h5C); cycle();
    drive(1'b1, 1'b1, 1'b0, 8'h00); cycle();
    chk("t4_err",   {31'd0, wb_if.err_o}, 32'd1);
    chk("t4_level", {27'd0, level},       32'd1);

    // Simultaneous push and pop at level 1, then random traffic across pointer wrap.
    m_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 8'hA5); cycle();
    chk("t5_level", {27'd0, level},  32'd1);
    chk("t5_head",  {24'd0, m_data}, 32'hA5);
    for (int i = 0; i < 40; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      drive(1'($urandom_range(0, 3) != 0), 1'b1, 1'($urandom_range(0, 7) != 0), 8'($urandom));
      cycle();
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    m_ready = 1'b1;
    repeat (18) cycle();

    // stb without cyc is ignored; dropping cyc after accept keeps the response.
    m_ready = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 8'h77); cycle();
    chk("t6_no_push", {27'd0, level}, 32'd0);
    drive(1'b1, 1'b1, 1'b1, 8'h78); cycle();
    drive(1'b0, 1'b1, 1'b1, 8'h79); cycle();
    chk("t6_level", {27'd0, level},  32'd1);
    chk("t6_data",  {24'd0, m_data}, 32'h78);
    m_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    repeat (3) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
